// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the xfft frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Config word bit that selects forward transform when set.
  localparam int CFG_FWD       = 0;
  localparam int NFFT_LOG2_DEF = 10;
  localparam int DATA_W_DEF    = 16;
  localparam int CFG_W_DEF     = 8;

endpackage

// File: rtl/fft_out_tagger.sv
// Output side of the sequencer: accepts core result beats, tags them with a
// bin index, registers them, and flags frame-boundary (tlast) mismatches.
module fft_out_tagger
  import fft_ctrl_pkg::*;
#(
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  en_i,
  input  logic                  cnt_clr_i,
  input  logic                  err_clr_i,
  input  logic [2*DATA_W-1:0]   m_tdata_i,
  input  logic                  m_tvalid_i,
  input  logic                  m_tlast_i,
  output logic                  last_beat_o,
  output logic [DATA_W-1:0]     out_re_o,
  output logic [DATA_W-1:0]     out_im_o,
  output logic [NFFT_LOG2-1:0]  out_idx_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  output logic                  err_o
);

  logic [NFFT_LOG2-1:0] out_cnt_q;
  logic [DATA_W-1:0]    out_re_q;
  logic [DATA_W-1:0]    out_im_q;
  logic [NFFT_LOG2-1:0] out_idx_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 err_q;
  logic                 beat;
  logic                 at_last;

  assign beat        = en_i && m_tvalid_i;
  assign at_last     = (out_cnt_q == '1);
  assign last_beat_o = beat && at_last;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      out_cnt_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= beat;
      out_last_q  <= beat && at_last;
      if (beat) begin
        out_re_q  <= m_tdata_i[DATA_W-1:0];
        out_im_q  <= m_tdata_i[2*DATA_W-1:DATA_W];
        out_idx_q <= out_cnt_q;
        out_cnt_q <= out_cnt_q + 1'b1;
        // tlast must coincide exactly with the final bin
        if (m_tlast_i != at_last) err_q <= 1'b1;
      end
      if (cnt_clr_i) out_cnt_q <= '0;
      if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign out_re_o    = out_re_q;
  assign out_im_o    = out_im_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the xfft AXI-Stream ports: config, N-sample load with
// tlast, N-bin drain with index tagging, single-shot or continuous operation.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CFG_W     = CFG_W_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  dir_ifft,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic [DATA_W-1:0]     src_re,
  input  logic [DATA_W-1:0]     src_im,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [CFG_W-1:0]      cfg_tdata,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [2*DATA_W-1:0]   s_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic                  s_tlast,
  input  logic [2*DATA_W-1:0]   m_tdata,
  input  logic                  m_tvalid,
  input  logic                  m_tlast,
  output logic                  m_tready,
  output logic [DATA_W-1:0]     out_re,
  output logic [DATA_W-1:0]     out_im,
  output logic [NFFT_LOG2-1:0]  out_idx,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_tlast,
  output logic [15:0]           frame_cnt
);

  localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;

  state_e               state_q;
  logic [NFFT_LOG2-1:0] in_cnt_q;
  logic [CFG_W-1:0]     cfg_q;
  logic [CFG_W-1:0]     cfg_d;
  logic                 stop_pend_q;
  logic                 frame_done_q;
  logic [15:0]          frame_cnt_q;
  logic                 in_load;
  logic                 in_xfer;
  logic                 in_last_xfer;
  logic                 start_ok;
  logic                 last_beat;

  always_comb begin
    cfg_d          = '0;
    cfg_d[CFG_FWD] = ~dir_ifft;
  end

  assign in_load      = (state_q == ST_LOAD);
  assign in_xfer      = in_load && src_valid && s_tready;
  assign in_last_xfer = in_xfer && (in_cnt_q == LAST_IDX);
  assign start_ok     = (state_q == ST_IDLE) && start;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      cfg_q        <= '0;
      stop_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q != ST_IDLE && stop) stop_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_CONFIG;
            cfg_q       <= cfg_d;
            // a stop arriving with start still allows exactly one frame
            stop_pend_q <= stop;
          end
        end
        ST_CONFIG: begin
          if (cfg_tready) begin
            state_q  <= ST_LOAD;
            in_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          if (in_xfer) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == LAST_IDX) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_beat) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
          end
        end
        ST_DONE: begin
          if (continuous && !stop_pend_q && !stop) begin
            state_q <= ST_CONFIG;
            cfg_q   <= cfg_d;
          end else begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fft_out_tagger #(
    .NFFT_LOG2 (NFFT_LOG2),
    .DATA_W    (DATA_W)
  ) u_tagger (
    .sys_clk_i   (sys_clk),
    .sys_rst_i   (sys_rst),
    .en_i        (state_q == ST_DRAIN),
    .cnt_clr_i   (in_last_xfer),
    .err_clr_i   (start_ok),
    .m_tdata_i   (m_tdata),
    .m_tvalid_i  (m_tvalid),
    .m_tlast_i   (m_tlast),
    .last_beat_o (last_beat),
    .out_re_o    (out_re),
    .out_im_o    (out_im),
    .out_idx_o   (out_idx),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .err_o       (err_tlast)
  );

  assign busy       = (state_q != ST_IDLE);
  assign cfg_tvalid = (state_q == ST_CONFIG);
  assign cfg_tdata  = cfg_q;
  assign s_tvalid   = in_load && src_valid;
  assign src_ready  = in_load && s_tready;
  assign s_tdata    = in_load ? {src_im, src_re} : '0;
  assign s_tlast    = in_load && (in_cnt_q == LAST_IDX);
  assign m_tready   = (state_q == ST_DRAIN);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with N=8: an echo core model feeds a scoreboard of
// expected bins; directed steps cover config, gaps, continuous/stop, errors, reset.
module tb_fft_frame_ctrl;

  localparam int NL = 3;
  localparam int DW = 16;
  localparam int CW = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst, start, dir_ifft, continuous, stop;
  logic [DW-1:0]   src_re, src_im;
  logic            src_valid, src_ready;
  logic [CW-1:0]   cfg_tdata;
  logic            cfg_tvalid, cfg_tready;
  logic [2*DW-1:0] s_tdata;
  logic            s_tvalid, s_tready, s_tlast;
  logic [2*DW-1:0] m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [DW-1:0]   out_re, out_im;
  logic [NL-1:0]   out_idx;
  logic            out_valid, out_last, busy, frame_done, err_tlast;
  logic [15:0]     frame_cnt;

  fft_frame_ctrl #(.NFFT_LOG2(NL), .DATA_W(DW), .CFG_W(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .dir_ifft(dir_ifft),
    .continuous(continuous), .stop(stop), .src_re(src_re), .src_im(src_im),
    .src_valid(src_valid), .src_ready(src_ready), .cfg_tdata(cfg_tdata),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .frame_done(frame_done),
    .err_tlast(err_tlast), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [NL-1:0]   idx;
    logic [2*DW-1:0] data;
    logic            lst;
  } exp_t;

  exp_t            sb[$];
  logic [2*DW-1:0] core_buf[8];
  logic [CW-1:0]   exp_cfg;
  int n_chk = 0, n_fail = 0;
  int cfg_delay = 0, cfg_wait = 0, last_cfg_cycles = 0;
  int sample_no = 0, core_cnt = 0, beat = 0, tlast_beat = 7;
  int done_seen = 0, outs_seen = 0, exp_fc = 0;
  bit gaps = 0, emitting = 0, start_now = 0, stop_now = 0, rst_now = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] gen(input int n);
    logic [DW-1:0] re, im;
    re = DW'(n * 11 + 3);
    im = DW'(n * 37 + 5);
    return {im, re};
  endfunction

  // One clock: check outputs at negedge, drive the next inputs, then resolve
  // the handshakes that will complete at the coming rising edge.
  task automatic step();
    exp_t e;
    bit   rst_cyc;
    @(negedge sys_clk);
    if (out_valid) begin
      outs_seen++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", {out_im, out_re}, e.data);
        chk("out_idx", out_idx, e.idx);
        chk("out_last", out_last, e.lst);
        $display("bin idx=%0d data=%08h last=%0b", out_idx, {out_im, out_re}, out_last);
      end
    end
    if (frame_done) done_seen++;
    if (cfg_tvalid) chk("cfg_tdata", cfg_tdata, exp_cfg);

    rst_cyc   = rst_now;
    sys_rst   = rst_now;
    start     = rst_now ? 1'b0 : start_now;
    stop      = rst_now ? 1'b0 : stop_now;
    rst_now   = 0;
    start_now = 0;
    stop_now  = 0;
    {src_im, src_re} = gen(sample_no);
    cfg_tready = !rst_cyc && cfg_tvalid && (cfg_wait >= cfg_delay);
    src_valid  = !rst_cyc && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    s_tready   = !rst_cyc && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    m_tvalid   = !rst_cyc && emitting && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    m_tdata    = emitting ? core_buf[beat] : '0;
    m_tlast    = emitting && (beat == tlast_beat);
    #1;
    if (rst_cyc) begin
      cfg_wait = 0; core_cnt = 0; beat = 0; emitting = 0;
      sb.delete();
      return;
    end
    if (cfg_tvalid) begin
      if (cfg_tready) begin
        last_cfg_cycles = cfg_wait + 1;
        cfg_wait = 0;
      end else cfg_wait++;
    end
    if (m_tvalid && m_tready) begin
      sb.push_back('{idx: NL'(beat), data: core_buf[beat], lst: (beat == 7)});
      beat++;
      if (beat == 8) begin emitting = 0; core_cnt = 0; beat = 0; end
    end
    if (s_tvalid && s_tready) begin
      chk("s_in_frame", (core_cnt < 8) && !emitting, 1);
      chk("s_tdata", s_tdata, gen(sample_no));
      chk("s_tlast", s_tlast, core_cnt == 7);
      if (core_cnt < 8) core_buf[core_cnt] = s_tdata;
      sample_no++;
      core_cnt++;
      if (core_cnt == 8) begin emitting = 1; beat = 0; end
    end
  endtask

  task automatic run_frames(input int n, input int budget);
    int target;
    target = done_seen + n;
    for (int i = 0; i < budget && done_seen < target; i++) step();
    chk("frame_timeout", done_seen >= target, 1);
    step();
    step();
  endtask

  task automatic frame_checks(input string tag, input int d0, input int o0, input int s0);
    chk({tag, "_done"}, done_seen - d0, 1);
    chk({tag, "_outs"}, outs_seen - o0, 8);
    chk({tag, "_samples"}, sample_no - s0, 8);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fcnt"}, frame_cnt, exp_fc);
  endtask

  task automatic check_zero(input string tag);
    @(negedge sys_clk);
    chk(tag, {busy, cfg_tvalid, cfg_tdata, s_tvalid, s_tlast, s_tdata, src_ready,
              m_tready, out_re, out_im, out_idx, out_valid, out_last, frame_done,
              err_tlast, frame_cnt}, '0);
  endtask

  initial begin
    int d0, o0, s0;
    bit stop_sent;
    sys_rst = 1; start = 0; dir_ifft = 0; continuous = 0; stop = 0;
    src_re = 0; src_im = 0; src_valid = 0; cfg_tready = 0; s_tready = 0;
    m_tdata = 0; m_tvalid = 0; m_tlast = 0; exp_cfg = 8'h01;

    rst_now = 1; step();
    rst_now = 1; step();
    check_zero("reset_outs");

    // Forward frame, config handshake delayed 3 cycles.
    dir_ifft = 0; exp_cfg = 8'h01; cfg_delay = 3;
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    run_frames(1, 300);
    exp_fc++;
    chk("t1_cfg_cycles", last_cfg_cycles, 4);
    chk("t1_err", err_tlast, 0);
    frame_checks("t1", d0, o0, s0);
    cfg_delay = 0;

    // Inverse frame with random source and core stalls.
    dir_ifft = 1; exp_cfg = 8'h00; gaps = 1;
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    run_frames(1, 600);
    exp_fc++;
    frame_checks("t2", d0, o0, s0);
    gaps = 0;

    // Early m_tlast on beat 5 raises a sticky error; next start clears it.
    dir_ifft = 0; exp_cfg = 8'h01; tlast_beat = 5;
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    run_frames(1, 300);
    exp_fc++;
    frame_checks("t4", d0, o0, s0);
    chk("t4_err_set", err_tlast, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t4_err_sticky", err_tlast, 1);
    tlast_beat = 7;
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    step();
    step();
    chk("t4_err_cleared", err_tlast, 0);
    run_frames(1, 300);
    exp_fc++;
    frame_checks("t4b", d0, o0, s0);
    chk("t4b_err", err_tlast, 0);

    // Start during DRAIN is ignored.
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    for (int i = 0; i < 200 && !(emitting && beat == 2); i++) step();
    chk("t6_reach_drain", emitting && beat == 2, 1);
    start_now = 1;
    run_frames(1, 200);
    for (int i = 0; i < 10; i++) step();
    exp_fc++;
    frame_checks("t6", d0, o0, s0);

    // Reset in LOAD after 4 samples, then a clean frame.
    start_now = 1;
    for (int i = 0; i < 200 && core_cnt < 4; i++) step();
    chk("t5_reach_load", core_cnt, 4);
    rst_now = 1;
    step();
    check_zero("t5_rst_outs");
    exp_fc = 0;
    d0 = done_seen; o0 = outs_seen; s0 = sample_no;
    start_now = 1;
    run_frames(1, 300);
    exp_fc++;
    frame_checks("t5", d0, o0, s0);

    // Continuous run stopped during the third frame's LOAD.
    rst_now = 1; step();
    exp_fc = 0;
    continuous = 1; gaps = 1; stop_sent = 0;
    d0 = done_seen;
    start_now = 1;
    for (int i = 0; i < 2000 && done_seen - d0 < 3; i++) begin
      if (!stop_sent && done_seen - d0 == 2 && core_cnt == 3 && !emitting) begin
        stop_now = 1;
        stop_sent = 1;
      end
      step();
    end
    chk("t3_stop_sent", stop_sent, 1);
    for (int i = 0; i < 40; i++) step();
    chk("t3_frames", done_seen - d0, 3);
    chk("t3_busy", busy, 0);
    chk("t3_fcnt", frame_cnt, 16'd3);
    chk("t3_sb_empty", sb.size(), 0);
    continuous = 0; gaps = 0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
